// File: rtl/text_line_builder_pkg.sv
// Shared types and font constants for the text line builder (package my_types).
package my_types;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN
   } state_e;

   localparam int GLYPH_W = 8;
   localparam int GLYPH_H = 16;

   localparam int unsigned CODE_BLANK  = 0;
   localparam int unsigned CODE_SOLID  = 1;
   localparam int unsigned CODE_DIGIT0 = 2;
   localparam int unsigned CODE_DIGIT9 = 11;

   // Seven-segment style digits: segments a..g map to seg[6]..seg[0].
   function automatic logic [7:0] digit_row(input int unsigned d, input logic [3:0] r);
      logic [6:0] seg;
      logic [7:0] px;
      case (d)
         0:       seg = 7'b1111110;
         1:       seg = 7'b0110000;
         2:       seg = 7'b1101101;
         3:       seg = 7'b1111001;
         4:       seg = 7'b0110011;
         5:       seg = 7'b1011011;
         6:       seg = 7'b1011111;
         7:       seg = 7'b1110000;
         8:       seg = 7'b1111111;
         9:       seg = 7'b1111011;
         default: seg = '0;
      endcase
      px = '0;
      if (r == 4'd2) begin
         px = seg[6] ? 8'h7E : 8'h00;
      end else if (r >= 4'd3 && r <= 4'd7) begin
         px = (seg[1] ? 8'h40 : 8'h00) | (seg[5] ? 8'h02 : 8'h00);
      end else if (r == 4'd8) begin
         px = seg[0] ? 8'h7E : 8'h00;
      end else if (r >= 4'd9 && r <= 4'd12) begin
         px = (seg[2] ? 8'h40 : 8'h00) | (seg[4] ? 8'h02 : 8'h00);
      end else if (r == 4'd13) begin
         px = seg[3] ? 8'h7E : 8'h00;
      end
      return px;
   endfunction

endpackage

// File: rtl/text_line_builder_font.sv
// Font ROM: one glyph row per code, registered output, one-cycle read latency, no reset.
module text_font_rom
   import my_types::*;
#(
   parameter int CODE_W = 6
) (
   input  logic                         clock,
   input  logic [CODE_W-1:0]            code,
   input  logic [$clog2(GLYPH_H)-1:0]   row,
   output logic [GLYPH_W-1:0]           glyph_q
);

   logic [GLYPH_W-1:0] glyph_d;

   // Codes outside the table fall through to a blank row.
   always_comb begin
      glyph_d = '0;
      if (code == CODE_W'(CODE_SOLID)) begin
         glyph_d = '1;
      end else if (code >= CODE_W'(CODE_DIGIT0) && code <= CODE_W'(CODE_DIGIT9)) begin
         glyph_d = digit_row(32'(code) - CODE_DIGIT0, row);
      end
   end

   always_ff @(posedge clock) begin
      glyph_q <= glyph_d;
   end

endmodule

// File: rtl/text_line_builder.sv
// Renders one pixel row of a text line through the font ROM, one char per cycle.
// Optional per-character inversion is enabled with the TEXT_INVERT_EN macro.
module text_line_builder #(
   parameter int NUM_CHARS = 17,
   parameter int CODE_W    = 6,
   parameter int GLYPH_W   = 8,
   parameter int GLYPH_H   = 16
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          req,
   input  logic [$clog2(GLYPH_H)-1:0]    row,
   input  logic [NUM_CHARS*CODE_W-1:0]   chars,
`ifdef TEXT_INVERT_EN
   input  logic [NUM_CHARS-1:0]          inv_mask,
`endif
   output logic                          ready,
   output logic                          valid,
   output logic [NUM_CHARS*GLYPH_W-1:0]  q
);

   import my_types::*;

   localparam int ROW_W = $clog2(GLYPH_H);
   localparam int IDX_W = $clog2(NUM_CHARS + 1);

   state_e                         state_q, state_d;
   logic [IDX_W-1:0]               idx_q, idx_d;
   logic [ROW_W-1:0]               row_q, row_d;
   logic [NUM_CHARS*CODE_W-1:0]    chars_q, chars_d;
   logic [NUM_CHARS*GLYPH_W-1:0]   shadow_q, shadow_d;
   logic [NUM_CHARS*GLYPH_W-1:0]   q_q, q_d;
   logic                           valid_q, valid_d;
`ifdef TEXT_INVERT_EN
   logic [NUM_CHARS-1:0]           inv_q, inv_d;
`endif

   logic [CODE_W-1:0]              code_sel;
   logic [GLYPH_W-1:0]             glyph;
   logic [GLYPH_W-1:0]             pix;
   logic [IDX_W-1:0]               wr_idx;
   logic                           wr_en;

   always_comb begin
      code_sel = '0;
      for (int unsigned i = 0; i < NUM_CHARS; i++) begin
         if (idx_q == IDX_W'(i)) code_sel = chars_q[(NUM_CHARS-1-i)*CODE_W +: CODE_W];
      end
   end

   text_font_rom #(.CODE_W(CODE_W)) u_rom (
      .clock   (clock),
      .code    (code_sel),
      .row     (row_q),
      .glyph_q (glyph)
   );

   // The ROM output trails the index by one edge, so slot idx-1 is written
   // during FETCH and the last slot in DRAIN.
   assign wr_idx = idx_q - 1'b1;
   assign wr_en  = (state_q == FETCH && idx_q != '0) || (state_q == DRAIN);

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      row_d    = row_q;
      chars_d  = chars_q;
      shadow_d = shadow_q;
      q_d      = q_q;
      valid_d  = 1'b0;
      pix      = glyph;
`ifdef TEXT_INVERT_EN
      inv_d    = inv_q;
`endif
      case (state_q)
         IDLE: begin
            if (req) begin
               state_d = FETCH;
               idx_d   = '0;
               row_d   = row;
               chars_d = chars;
`ifdef TEXT_INVERT_EN
               inv_d   = inv_mask;
`endif
            end
         end
         FETCH: begin
            idx_d = idx_q + 1'b1;
            if (idx_q == IDX_W'(NUM_CHARS - 1)) state_d = DRAIN;
         end
         DRAIN: begin
            state_d = IDLE;
            valid_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (wr_en) begin
         for (int unsigned i = 0; i < NUM_CHARS; i++) begin
            if (wr_idx == IDX_W'(i)) begin
`ifdef TEXT_INVERT_EN
               pix = glyph ^ {GLYPH_W{inv_q[NUM_CHARS-1-i]}};
`endif
               shadow_d[(NUM_CHARS-1-i)*GLYPH_W +: GLYPH_W] = pix;
            end
         end
      end

      if (state_q == DRAIN) q_d = shadow_d;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         row_q    <= '0;
         chars_q  <= '0;
         shadow_q <= '0;
         q_q      <= '0;
         valid_q  <= 1'b0;
`ifdef TEXT_INVERT_EN
         inv_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         row_q    <= row_d;
         chars_q  <= chars_d;
         shadow_q <= shadow_d;
         q_q      <= q_d;
         valid_q  <= valid_d;
`ifdef TEXT_INVERT_EN
         inv_q    <= inv_d;
`endif
      end
   end

   assign ready = (state_q == IDLE);
   assign valid = valid_q;
   assign q     = q_q;

endmodule

// File: doc/text_line_builder.md
TEXT_LINE_BUILDER -- requirements
Module: text_line_builder

Interface
REQ-001 SHALL have parameter NUM_CHARS, default 17: characters per line, legal range 1..32.
REQ-002 SHALL have parameter CODE_W, default 6: character code width, legal range 4..8.
REQ-003 SHALL have parameter GLYPH_W, default 8: glyph width in pixels, fixed at 8.
REQ-004 SHALL have parameter GLYPH_H, default 16: glyph height in rows, fixed at 16.
REQ-005 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port req, input, 1 bit: line build request.
REQ-008 SHALL have port row, input, 4 bits: glyph row to render.
REQ-009 SHALL have port chars, input, NUM_CHARS*CODE_W bits: character codes; char 0 is in the MSBs.
REQ-010 SHALL have port inv_mask, input, NUM_CHARS bits, present only with TEXT_INVERT_EN: bit NUM_CHARS-1-i inverts char i.
REQ-011 SHALL have port ready, output, 1 bit: idle and able to accept req.
REQ-012 SHALL have port valid, output, 1 bit: one-cycle pulse when q has been updated.
REQ-013 SHALL have port q, output, NUM_CHARS*GLYPH_W bits: rendered pixel line; char 0 is in the MSBs and the MSB is the leftmost pixel.

Function
REQ-014 SHALL implement the states IDLE, FETCH and DRAIN. ready SHALL be 1 only in IDLE.
REQ-015 SHALL accept a request on an edge where req=1 and the state is IDLE (edge E0), capture row, chars (and inv_mask), and go to FETCH with index 0.
REQ-016 In FETCH, on edges E1..E_N (N=NUM_CHARS), SHALL have the font ROM register the glyph row of char k-1, with the index incrementing each edge.
REQ-017 SHALL move to DRAIN on the edge E_N.
REQ-018 SHALL write each ROM output into its slot one edge after it is registered; the final slot is written at E_{N+1}.
REQ-019 At E_{N+1}, SHALL return to IDLE and assert valid for exactly one cycle. The accept-to-valid latency is N+1 cycles.
REQ-020 SHALL build all slots in a shadow register and copy it to q only at E_{N+1}; q SHALL hold its value between completions.
REQ-021 SHALL ignore req while not IDLE; requests are not queued.
REQ-022 With req held high, SHALL re-accept on the first IDLE edge after valid, giving a request period of N+2 cycles.
REQ-023 SHALL ignore changes on chars, row or inv_mask after E0 until the next accept.
REQ-024 SHALL render codes that are undefined in the font table as blank (8'h00).
REQ-025 SHALL work with NUM_CHARS=1: valid follows E0 by 2 cycles.

Reset
REQ-026 While reset_n=0, asynchronously: state IDLE, index 0, ready=1, valid=0, q=0, shadow register 0.
REQ-027 A reset during FETCH or DRAIN SHALL abort the build with no valid pulse; the first accept is possible on the first edge after reset_n rises.

Configuration
REQ-028 With TEXT_INVERT_EN defined: the inv_mask port SHALL be present, and slot i SHALL hold the bitwise NOT of its glyph row when inv_mask bit NUM_CHARS-1-i was 1 at accept.
REQ-029 Without TEXT_INVERT_EN: inv_mask and all related logic SHALL be absent, and glyph rows pass unmodified.

Structure
REQ-030 SHALL place the state enum, GLYPH_W, GLYPH_H and font code constants in the shared package my_types. These constants are: CODE_BLANK=0; CODE_SOLID=1, which is 8'hFF on every row; CODE_DIGIT0..9=2..11.
REQ-031 SHALL use one sub-module, text_font_rom: clock, code and row inputs, 8-bit registered output, 1-cycle read latency, no reset.

Verification
REQ-032 Reset: hold reset_n=0 -> ready=1, valid=0, q=0; pulse reset mid-build -> same values with no valid pulse.
REQ-033 Blank line: NUM_CHARS=17, all codes 0, row 5, one-cycle req -> ready=0 for 18 cycles, valid pulses 18 cycles after accept, q=136'h0.
REQ-034 Slot ordering: char 0=CODE_SOLID, others 0, row 3 -> q[135:128]=8'hFF and q[127:0]=0; char 16=CODE_SOLID only -> q[7:0]=8'hFF and the rest 0.
REQ-035 Back-to-back: req held high for 60 cycles -> valid pulses at 19-cycle spacing; req during busy is not accepted; chars changed after E0 do not affect q.
REQ-036 Invert: with TEXT_INVERT_EN, all codes 0 and inv_mask MSB=1 -> q[135:128]=8'hFF, rest 0; without the macro the inv_mask port does not exist.
REQ-037 NUM_CHARS=1: CODE_SOLID, row 0 -> valid 2 cycles after accept, q=8'hFF.
